// File: rtl/store_write_buffer.sv
// Posted-store FIFO between the core data port and data memory, with a
// youngest-match forwarding lookup so loads never observe stale memory.
module store_write_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     memwrite,
    input  logic [AW-1:0]            dataadr,
    input  logic [DW-1:0]            writedata,
    output logic                     stall,
    output logic                     mem_valid,
    input  logic                     mem_ready,
    output logic [AW-1:0]            mem_addr,
    output logic [DW-1:0]            mem_wdata,
    input  logic [AW-1:0]            lookup_addr,
    output logic                     fwd_hit,
    output logic [DW-1:0]            fwd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          push;
    logic          pop;

    // Memory handshake: the head transfers on a rising edge where mem_valid and
    // mem_ready are both high; while mem_valid is high and mem_ready low the head
    // (mem_addr/mem_wdata) is held stable. Push only looks at full, never mem_ready.
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(DEPTH));
    assign count     = count_q;
    assign stall     = memwrite & full;
    assign push      = memwrite & ~full;
    assign mem_valid = ~empty;
    assign pop       = mem_valid & mem_ready;
    assign mem_addr  = empty ? '0 : addr_q[rd_ptr];
    assign mem_wdata = empty ? '0 : data_q[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry payloads need no reset: validity comes only from rd_ptr and count.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= dataadr;
            data_q[wr_ptr] <= writedata;
        end
    end

    // Walk valid entries oldest to youngest so the last match is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[idx][AW-1:2] == lookup_addr[AW-1:2])) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[idx];
            end
        end
    end
endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: directed scenarios plus random traffic checked
// against a queue-based model of the posted-store buffer.
module tb_store_write_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          memwrite;
    logic [AW-1:0] dataadr;
    logic [DW-1:0] writedata;
    logic          stall;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] lookup_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [2:0]    count;
    logic          empty;
    logic          full;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .stall(stall), .mem_valid(mem_valid),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .lookup_addr(lookup_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data),
        .count(count), .empty(empty), .full(full)
    );

    // clock / reset
    always #5 clk = ~clk;

    // model: buffered stores oldest first, {addr, data}
    logic [AW+DW-1:0] exp_q[$];
    // addresses the DUT actually handed to memory
    logic [AW-1:0]    mem_log[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_fwd(input logic [AW-1:0] la, output logic hit,
                                      output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        foreach (exp_q[i]) begin
            if (exp_q[i][AW+DW-1:DW+2] == la[AW-1:2]) begin
                hit = 1'b1;
                d   = exp_q[i][DW-1:0];
            end
        end
    endfunction

    task automatic do_reset(input int cycles, input logic mw, input logic rdy);
        reset = 1'b0; memwrite = mw; mem_ready = rdy;
        dataadr = 32'd200; writedata = 32'd99; lookup_addr = 32'd0;
        repeat (cycles) @(posedge clk);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1; memwrite = 1'b0; mem_ready = 1'b0;
    endtask

    // driver: one cycle, called at a negedge; checks outputs then advances the model
    task automatic step(input logic mw, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                        input logic rdy, input logic [AW-1:0] la);
        logic             hit;
        logic [DW-1:0]    d;
        logic [AW+DW-1:0] e;
        int               sz;
        memwrite = mw; dataadr = adr; writedata = wd; mem_ready = rdy; lookup_addr = la;
        #1;
        sz = exp_q.size();
        e  = (sz != 0) ? exp_q[0] : '0;
        chk("count", 64'(count), 64'(sz));
        chk("empty", 64'(empty), 64'(sz == 0));
        chk("full", 64'(full), 64'(sz == DEPTH));
        chk("stall", 64'(stall), 64'(mw && sz == DEPTH));
        chk("mem_valid", 64'(mem_valid), 64'(sz != 0));
        chk("mem_addr", 64'(mem_addr), 64'(e[AW+DW-1:DW]));
        chk("mem_wdata", 64'(mem_wdata), 64'(e[DW-1:0]));
        model_fwd(la, hit, d);
        chk("fwd_hit", 64'(fwd_hit), 64'(hit));
        chk("fwd_data", 64'(fwd_data), 64'(d));
        if (mem_valid && mem_ready) mem_log.push_back(mem_addr);
        @(posedge clk);
        if (sz != 0 && rdy) void'(exp_q.pop_front());
        if (mw && sz != DEPTH) exp_q.push_back({adr, wd});
        @(negedge clk);
    endtask

    task automatic look(input string tag, input logic [AW-1:0] la, input logic h,
                        input logic [DW-1:0] d);
        memwrite = 1'b0; lookup_addr = la;
        #1;
        chk({tag, "_hit"}, 64'(fwd_hit), 64'(h));
        chk({tag, "_data"}, 64'(fwd_data), 64'(d));
    endtask

    logic [AW-1:0] order2 [5];
    logic          accepted;
    logic          rdy;

    initial begin
        order2 = '{32'd80, 32'd84, 32'd88, 32'd92, 32'd96};

        // reset state
        do_reset(2, 1'b0, 1'b0);
        #1;
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_fwd_hit", 64'(fwd_hit), 64'd0);
        @(negedge clk);
        step(1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

        // fill to full, fifth store stalls, then drain in order
        mem_log.delete();
        step(1'b1, 32'd80, 32'd5, 1'b0, 32'd80);
        step(1'b1, 32'd84, 32'd7, 1'b0, 32'd80);
        step(1'b1, 32'd88, 32'd9, 1'b0, 32'd88);
        step(1'b1, 32'd92, 32'd11, 1'b0, 32'd92);
        chk("t2_count", 64'(count), 64'd4);
        chk("t2_full", 64'(full), 64'd1);
        step(1'b1, 32'd96, 32'd13, 1'b0, 32'd84);
        step(1'b1, 32'd96, 32'd13, 1'b1, 32'd84);
        step(1'b1, 32'd96, 32'd13, 1'b1, 32'd96);
        repeat (5) step(1'b0, 32'd0, 32'd0, 1'b1, 32'd96);
        chk("t2_nwrites", 64'(mem_log.size()), 64'd5);
        foreach (order2[i]) begin
            if (i < mem_log.size()) chk($sformatf("t2_order%0d", i), 64'(mem_log[i]), 64'(order2[i]));
        end

        // forwarding, youngest wins, word-granular match
        step(1'b1, 32'd84, 32'd3, 1'b0, 32'd84);
        step(1'b1, 32'd84, 32'd7, 1'b0, 32'd84);
        look("t3_84", 32'd84, 1'b1, 32'd7);
        look("t3_86", 32'd86, 1'b1, 32'd7);
        look("t3_88", 32'd88, 1'b0, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 32'd88);

        // simultaneous push/pop at count 2, pointer wrap
        step(1'b1, 32'd300, 32'd1000, 1'b1, 32'd300);
        chk("t4_count_before", 64'(count), 64'd2);
        for (int i = 0; i < 10; i++) step(1'b1, 32'd400 + 32'(4 * i), 32'(i + 2000), 1'b1, 32'd400);
        chk("t4_count_after", 64'(count), 64'd2);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);

        // reset with live entries, simultaneous push and pop
        step(1'b1, 32'd500, 32'd1, 1'b0, 32'd0);
        step(1'b1, 32'd504, 32'd2, 1'b0, 32'd0);
        step(1'b1, 32'd508, 32'd3, 1'b0, 32'd0);
        chk("t5_count", 64'(count), 64'd3);
        mem_log.delete();
        do_reset(1, 1'b1, 1'b1);
        #1;
        chk("t5_count_rst", 64'(count), 64'd0);
        chk("t5_valid_rst", 64'(mem_valid), 64'd0);
        @(negedge clk);
        repeat (3) step(1'b0, 32'd0, 32'd0, 1'b1, 32'd500);
        chk("t5_no_writes", 64'(mem_log.size()), 64'd0);

        // head stability under random mem_ready
        step(1'b1, 32'd120, 32'd55, 1'b0, 32'd0);
        step(1'b1, 32'd124, 32'd66, 1'b0, 32'd0);
        accepted = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            rdy = (i < 3) ? 1'b0 : ((i == 19) ? 1'b1 : 1'($urandom_range(0, 1)));
            chk("t6_hold_addr", 64'(mem_addr), 64'd120);
            chk("t6_hold_data", 64'(mem_wdata), 64'd55);
            step(1'b0, 32'd0, 32'd0, rdy, 32'd124);
            accepted = rdy;
        end
        repeat (2) step(1'b0, 32'd0, 32'd0, 1'b1, 32'd0);

        // random traffic against the model
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)),
                 32'd64 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3)),
                 $urandom,
                 ($urandom_range(0, 3) != 0),
                 32'd64 + 32'(4 * $urandom_range(0, 6)) + 32'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
